// File: rtl/operand_stage.sv
// RV32 decode/operand stage: register file, RAW/WAW scoreboard and a registered
// operand bundle for execute. Define OPSTAGE_BYPASS_EN for same-cycle writeback forwarding.
module operand_stage #(
   parameter int SIZE = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [SIZE-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [SIZE-1:0] alu_in1_o,
   output logic [SIZE-1:0] alu_in2_o,
   output logic            alu_en_o,
   output logic [3:0]      alu_select_o,
   output logic            br_en_o,
   output logic [2:0]      br_select_o,
   output logic [SIZE-1:0] br_target_o,
   output logic [4:0]      rd_out_o,
   output logic            illegal_o,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [SIZE-1:0] wb_data_i
);
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;

   typedef struct packed {
      logic            valid;
      logic [SIZE-1:0] in1;
      logic [SIZE-1:0] in2;
      logic            alu_en;
      logic [3:0]      alu_sel;
      logic            br_en;
      logic [2:0]      br_sel;
      logic [SIZE-1:0] target;
      logic [4:0]      rd;
      logic            illegal;
   } bundle_t;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2, rd;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign rs1    = instr_i[19:15];
   assign rs2    = instr_i[24:20];
   assign funct7 = instr_i[31:25];

   logic [SIZE-1:0] imm_i, imm_b;
   assign imm_i = {{(SIZE-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_b = {{(SIZE-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};

   // ---------------- decode ----------------
   logic       is_alu, is_br, use_rs1, use_rs2;
   logic [3:0] alu_sel;
   logic [2:0] br_sel;

   always_comb begin
      is_alu  = 1'b0;
      is_br   = 1'b0;
      use_rs2 = 1'b0;
      alu_sel = 4'd0;
      br_sel  = 3'd0;
      case (opcode)
         OP_R: begin
            is_alu  = 1'b1;
            use_rs2 = 1'b1;
            if      (funct7 == 7'b0000000 && funct3 == 3'b000) alu_sel = 4'd0;
            else if (funct7 == 7'b0100000 && funct3 == 3'b000) alu_sel = 4'd1;
            else if (funct7 == 7'b0000000 && funct3 == 3'b111) alu_sel = 4'd2;
            else if (funct7 == 7'b0000000 && funct3 == 3'b110) alu_sel = 4'd3;
            else begin
               is_alu  = 1'b0;
               use_rs2 = 1'b0;
            end
         end
         OP_I: begin
            is_alu = 1'b1;
            case (funct3)
               3'b000:  alu_sel = 4'd0;
               3'b111:  alu_sel = 4'd2;
               3'b110:  alu_sel = 4'd3;
               default: is_alu  = 1'b0;
            endcase
         end
         OP_B: begin
            // Branch_control compares unsigned only, so BLT/BGE stay illegal
            is_br   = 1'b1;
            use_rs2 = 1'b1;
            case (funct3)
               3'b000:  br_sel = 3'd0;
               3'b001:  br_sel = 3'd1;
               3'b110:  br_sel = 3'd3;
               3'b111:  br_sel = 3'd4;
               default: begin
                  is_br   = 1'b0;
                  use_rs2 = 1'b0;
               end
            endcase
         end
         default: ;
      endcase
   end

   assign use_rs1 = is_alu | is_br;

   // ---------------- register file ----------------
   logic [SIZE-1:0] regs_q [32];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (wb_valid_i && wb_rd_i != 5'd0) begin
         regs_q[wb_rd_i] <= wb_data_i;
      end
   end

   logic [SIZE-1:0] src1, src2;
   logic            byp1, byp2;

   always_comb begin
      src1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
      src2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`ifdef OPSTAGE_BYPASS_EN
      byp1 = wb_valid_i && rs1 != 5'd0 && wb_rd_i == rs1;
      byp2 = wb_valid_i && rs2 != 5'd0 && wb_rd_i == rs2;
`else
      byp1 = 1'b0;
      byp2 = 1'b0;
`endif
      if (byp1) src1 = wb_data_i;
      if (byp2) src2 = wb_data_i;
   end

   // ---------------- scoreboard / handshake ----------------
   logic [31:0] pending_q, pending_d;
   bundle_t     bun_q, bun_d;
   logic        hazard, accept;

   // WAW is not relieved by a same-cycle writeback; this keeps set and clear
   // of one pending bit from ever coinciding.
   assign hazard = (use_rs1 && rs1 != 5'd0 && pending_q[rs1] && !byp1) ||
                   (use_rs2 && rs2 != 5'd0 && pending_q[rs2] && !byp2) ||
                   (is_alu && rd != 5'd0 && pending_q[rd]);

   assign instr_ready_o = (!bun_q.valid || out_ready_i) && !hazard;
   assign accept        = instr_valid_i && instr_ready_o;

   always_comb begin
      bun_d     = bun_q;
      pending_d = pending_q;
      if (accept) begin
         bun_d.valid   = 1'b1;
         bun_d.in1     = src1;
         bun_d.in2     = (opcode == OP_I) ? imm_i : src2;
         bun_d.alu_en  = is_alu;
         bun_d.alu_sel = alu_sel;
         bun_d.br_en   = is_br;
         bun_d.br_sel  = br_sel;
         bun_d.target  = pc_i + imm_b;
         bun_d.rd      = is_alu ? rd : 5'd0;
         bun_d.illegal = !(is_alu || is_br);
      end else if (out_ready_i) begin
         bun_d.valid = 1'b0;
      end
      if (wb_valid_i && wb_rd_i != 5'd0) pending_d[wb_rd_i] = 1'b0;
      if (accept && is_alu && rd != 5'd0) pending_d[rd] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bun_q     <= '0;
         pending_q <= '0;
      end else begin
         bun_q     <= bun_d;
         pending_q <= pending_d;
      end
   end

   assign out_valid_o  = bun_q.valid;
   assign alu_in1_o    = bun_q.in1;
   assign alu_in2_o    = bun_q.in2;
   assign alu_en_o     = bun_q.alu_en;
   assign alu_select_o = bun_q.alu_sel;
   assign br_en_o      = bun_q.br_en;
   assign br_select_o  = bun_q.br_sel;
   assign br_target_o  = bun_q.target;
   assign rd_out_o     = bun_q.rd;
   assign illegal_o    = bun_q.illegal;
endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus a randomized
// run against a mnemonic-level reference model of decode, register file and scoreboard.
module tb_operand_stage;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic        instr_valid = 0, out_ready = 0, wb_valid = 0;
   logic [31:0] instr = 0, pc = 0, wb_data = 0;
   logic [4:0]  wb_rd = 0;
   logic        instr_ready, out_valid, alu_en, br_en, illegal;
   logic [31:0] alu_in1, alu_in2, br_target;
   logic [3:0]  alu_select;
   logic [2:0]  br_select;
   logic [4:0]  rd_out;

   operand_stage #(.SIZE(32)) dut (
      .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_en_o(alu_en), .alu_select_o(alu_select),
      .br_en_o(br_en), .br_select_o(br_select), .br_target_o(br_target), .rd_out_o(rd_out),
      .illegal_o(illegal), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data)
   );

`ifdef OPSTAGE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic v; logic [31:0] in1; logic [31:0] in2; logic alu_en; logic [3:0] asel;
      logic br_en; logic [2:0] bsel; logic [31:0] tgt; logic [4:0] rd; logic ill;
   } bund_t;

   bund_t dut_b;
   assign dut_b = {out_valid, alu_in1, alu_in2, alu_en, alu_select, br_en, br_select,
                   br_target, rd_out, illegal};

   int checks = 0, errors = 0;

   // ---------------- reference model ----------------
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bund_t       m_out;

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                         logic [4:0] rs1, logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
                                         logic [11:0] imm);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction
   function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                         logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] rdv(logic [4:0] r);
      if (r == 0) return 32'd0;
      if (BYP && wb_valid && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic bit busy(logic [4:0] r);
      return r != 0 && m_pend[r] && !(BYP && wb_valid && wb_rd == r);
   endfunction

   function automatic bund_t ref_decode(logic [31:0] ins, logic [31:0] p);
      bund_t b = '0;
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      b.v = 1; b.ill = 1;
      case (ins[6:0])
         7'h33: begin
            b.in1 = rdv(ins[19:15]); b.in2 = rdv(ins[24:20]);
            b.alu_en = 1; b.ill = 0; b.rd = ins[11:7];
            if      (f7 == 7'h00 && f3 == 0) b.asel = 0;   // ADD
            else if (f7 == 7'h20 && f3 == 0) b.asel = 1;   // SUB
            else if (f7 == 7'h00 && f3 == 7) b.asel = 2;   // AND
            else if (f7 == 7'h00 && f3 == 6) b.asel = 3;   // OR
            else begin b.alu_en = 0; b.ill = 1; b.rd = 0; end
         end
         7'h13: begin
            b.in1 = rdv(ins[19:15]); b.in2 = 32'($signed(ins[31:20]));
            b.alu_en = 1; b.ill = 0; b.rd = ins[11:7];
            if      (f3 == 0) b.asel = 0;
            else if (f3 == 7) b.asel = 2;
            else if (f3 == 6) b.asel = 3;
            else begin b.alu_en = 0; b.ill = 1; b.rd = 0; end
         end
         7'h63: begin
            b.in1 = rdv(ins[19:15]); b.in2 = rdv(ins[24:20]);
            b.tgt = p + 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            b.br_en = 1; b.ill = 0;
            if      (f3 == 0) b.bsel = 0;
            else if (f3 == 1) b.bsel = 1;
            else if (f3 == 6) b.bsel = 3;
            else if (f3 == 7) b.bsel = 4;
            else begin b.br_en = 0; b.ill = 1; end
         end
         default: ;
      endcase
      return b;
   endfunction

   // fields the specification leaves undefined are masked out
   function automatic bund_t vis(bund_t b);
      bund_t r = b;
      if (!r.v) return '0;
      if (r.ill) begin r.in1 = 0; r.in2 = 0; end
      if (!r.br_en) begin r.tgt = 0; r.bsel = 0; end
      if (!r.alu_en) r.asel = 0;
      return r;
   endfunction

   function automatic bit m_ready();
      bund_t d = ref_decode(instr, pc);
      bit h = 0;
      if (!d.ill) begin
         if (busy(instr[19:15])) h = 1;
         if (instr[6:0] != 7'h13 && busy(instr[24:20])) h = 1;
         if (d.alu_en && d.rd != 0 && m_pend[d.rd]) h = 1;
      end
      return (!m_out.v || out_ready) && !h;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_out = '0;
   endtask

   task automatic drive(bit v, logic [31:0] ins, logic [31:0] p, bit ordy,
                        bit wv, logic [4:0] wr, logic [31:0] wd);
      instr_valid = v; instr = ins; pc = p; out_ready = ordy;
      wb_valid = wv; wb_rd = wr; wb_data = wd;
   endtask

   // one clock edge for DUT and model; returns 1 time unit after the edge
   task automatic tick();
      bit    acc = instr_valid && m_ready();
      bund_t nb  = ref_decode(instr, pc);
      @(posedge clk);
      if (acc) m_out = nb;
      else if (out_ready) m_out.v = 0;
      if (wb_valid && wb_rd != 0) begin m_regs[wb_rd] = wb_data; m_pend[wb_rd] = 0; end
      if (acc && nb.alu_en && nb.rd != 0) m_pend[nb.rd] = 1;
      #1;
   endtask

   task automatic drain_pending();
      for (int r = 1; r < 32; r++)
         if (m_pend[r]) begin drive(0, 0, 0, 1, 1, 5'(r), $urandom); tick(); end
      drive(0, 0, 0, 1, 0, 0, 0); tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; drive(0, 0, 0, 0, 0, 0, 0); model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dut_b !== '0) begin errors++;
         $display("FAIL reset_outputs: got %h want 0", dut_b); end
      rst = 0; #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL reset_ready: got %b want 1", instr_ready); end
   endtask

   task automatic test_addi_raw();
      int lat = -1;
      drive(1, enc_i(0, 1, 0, 12'd5), 32'h0, 1, 0, 0, 0); #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL addi_ready: got %b want 1", instr_ready); end
      tick();
      checks++; if ({out_valid, alu_select, alu_in1, alu_in2, rd_out, alu_en} !==
                    {1'b1, 4'd0, 32'd0, 32'd5, 5'd1, 1'b1}) begin errors++;
         $display("FAIL addi_bundle: got %h want %h", dut_b, m_out); end
      drive(1, enc_r(0, 0, 2, 1, 1), 32'h4, 1, 0, 0, 0); #1;
      checks++; if (instr_ready !== 1'b0) begin errors++;
         $display("FAIL raw_stall: got %b want 0", instr_ready); end
      wb_valid = 1; wb_rd = 1; wb_data = 5; #1;
      checks++; if (instr_ready !== BYP) begin errors++;
         $display("FAIL raw_wb_ready: got %b want %b", instr_ready, BYP); end
      for (int k = 0; k < 4; k++) begin
         tick(); wb_valid = 0;
         if (out_valid === 1'b1) begin lat = k; break; end
      end
      instr_valid = 0;
      checks++; if (lat !== (BYP ? 0 : 1)) begin errors++;
         $display("FAIL raw_issue_delay: got %0d want %0d", lat, BYP ? 0 : 1); end
      checks++; if ({alu_in1, alu_in2, rd_out, alu_select} !== {32'd5, 32'd5, 5'd2, 4'd0})
         begin errors++; $display("FAIL raw_operands: got %h want %h", dut_b, m_out); end
   endtask

   task automatic test_branch();
      drive(0, 0, 0, 1, 1, 2, 32'd9); tick();
      drive(1, enc_b(3'b001, 1, 2, 13'h1FF8), 32'h100, 1, 0, 0, 0); #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL bne_ready: got %b want 1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if ({br_en, br_select, alu_en, br_target, rd_out, illegal} !==
                    {1'b1, 3'd1, 1'b0, 32'hF8, 5'd0, 1'b0}) begin errors++;
         $display("FAIL bne_bundle: got %h want %h", dut_b, m_out); end
      checks++; if ({alu_in1, alu_in2} !== {32'd5, 32'd9}) begin errors++;
         $display("FAIL bne_operands: got %h/%h want 5/9", alu_in1, alu_in2); end
   endtask

   task automatic test_backpressure();
      bund_t snap;
      drive(1, enc_i(0, 5, 0, 12'd7), 32'h20, 1, 0, 0, 0); tick();
      snap = dut_b;
      drive(1, enc_i(6, 6, 0, 12'd9), 32'h24, 0, 0, 0, 0); #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (instr_ready !== 1'b0) begin errors++;
            $display("FAIL bp_ready_%0d: got %b want 0", k, instr_ready); end
         tick();
         checks++; if (dut_b !== snap || out_valid !== 1'b1) begin errors++;
            $display("FAIL bp_hold_%0d: got %h want %h", k, dut_b, snap); end
      end
      out_ready = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release_ready: got %b want 1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if (vis(dut_b) !== vis(m_out) || rd_out !== 5'd6 || alu_in2 !== 32'd9)
         begin errors++; $display("FAIL bp_next: got %h want %h", dut_b, m_out); end
   endtask

   task automatic test_illegal_x0();
      logic [31:0] bad [4];
      bad[0] = enc_b(3'b100, 1, 2, 13'd16);       // BLT
      bad[1] = enc_b(3'b101, 1, 2, 13'd16);       // BGE
      bad[2] = enc_r(7'h01, 0, 9, 1, 1);          // MUL
      bad[3] = {20'h0, 5'd9, 7'h03};              // LB
      drain_pending();
      for (int k = 0; k < 4; k++) begin
         drive(1, bad[k], 32'h40, 1, 0, 0, 0); #1;
         checks++; if (instr_ready !== 1'b1) begin errors++;
            $display("FAIL ill_ready_%0d: got %b want 1", k, instr_ready); end
         tick();
         checks++; if ({out_valid, illegal, alu_en, br_en, rd_out} !==
                       {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin errors++;
            $display("FAIL ill_flags_%0d: got %h want %h", k, dut_b, m_out); end
      end
      // no scoreboard entry was made for rd=9 by the illegal ops
      drive(1, enc_i(0, 9, 0, 12'd3), 32'h50, 1, 0, 0, 0); #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL ill_no_pending: got %b want 1", instr_ready); end
      tick();
      drive(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF); tick();
      drive(1, enc_r(0, 0, 7, 0, 0), 32'h54, 1, 0, 0, 0); #1; tick(); instr_valid = 0;
      checks++; if ({out_valid, alu_in1, alu_in2} !== {1'b1, 64'd0}) begin errors++;
         $display("FAIL x0_read: got %h/%h want 0/0", alu_in1, alu_in2); end
   endtask

   task automatic test_reset_mid();
      drain_pending();
      drive(1, enc_i(0, 3, 0, 12'd1), 32'h60, 1, 0, 0, 0); tick();
      drive(1, enc_r(0, 0, 4, 3, 3), 32'h64, 0, 0, 0, 0); #1;
      checks++; if (instr_ready !== 1'b0) begin errors++;
         $display("FAIL rstmid_stall: got %b want 0", instr_ready); end
      rst = 1; #1;
      checks++; if (dut_b !== '0) begin errors++;
         $display("FAIL rstmid_clear: got %h want 0", dut_b); end
      model_reset();
      @(posedge clk); #1;
      rst = 0; out_ready = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL rstmid_ready: got %b want 1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if ({out_valid, alu_in1, alu_in2, rd_out} !== {1'b1, 64'd0, 5'd4}) begin
         errors++; $display("FAIL rstmid_add: got %h want %h", dut_b, m_out); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic [31:0] ins;
         logic [4:0]  a = 5'($urandom_range(0, 7)), b = 5'($urandom_range(0, 7));
         logic [4:0]  d = 5'($urandom_range(0, 7)), wr = 0;
         logic [2:0]  f3s [4];
         int          np = 0, kind = $urandom_range(0, 9);
         bit          wv = 0;
         case (kind)
            0, 1, 2: begin
               f3s = '{3'd0, 3'd0, 3'd7, 3'd6};
               np = $urandom_range(0, 3);
               ins = enc_r(np == 1 ? 7'h20 : 7'h00, f3s[np], d, a, b);
            end
            3, 4, 5: begin
               f3s = '{3'd0, 3'd7, 3'd6, 3'd0};
               ins = enc_i(f3s[$urandom_range(0, 2)], d, a, 12'($urandom));
            end
            6, 7, 8: begin
               f3s = '{3'd0, 3'd1, 3'd6, 3'd7};
               ins = enc_b(f3s[$urandom_range(0, 3)], a, b, {12'($urandom), 1'b0});
            end
            default: ins = $urandom();
         endcase
         np = 0;
         for (int r = 1; r < 8; r++) if (m_pend[r]) np++;
         if (np > 0 && $urandom_range(0, 2) != 0) begin
            do wr = 5'($urandom_range(1, 7)); while (!m_pend[wr]);
            wv = 1;
         end else if ($urandom_range(0, 15) == 0) wv = 1;   // x0 write
         drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
               wv, wr, $urandom);
         #1;
         checks++; if (instr_ready !== m_ready()) begin errors++;
            $display("FAIL rnd_ready_%0d: got %b want %b", i, instr_ready, m_ready()); end
         tick();
         checks++; if (vis(dut_b) !== vis(m_out)) begin errors++;
            $display("FAIL rnd_bundle_%0d: got %h want %h", i, vis(dut_b), vis(m_out)); end
      end
      drive(0, 0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_addi_raw();
      test_branch();
      test_backpressure();
      test_illegal_x0();
      test_reset_mid();
      drain_pending();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_stage.md
# operand_stage

Decode/operand stage placed directly upstream of the execute ALU and Branch_control. It accepts one RISC-V instruction per cycle over a valid/ready handshake and decodes it into ALU and branch select codes. It reads operands from an internal 32-entry register file and presents a registered operand bundle to the execute stage. ALU results return on a writeback port, which writes the register file and clears a per-register scoreboard used to stall RAW/WAW hazards.

## Interface
- SIZE, 32, datapath and register width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  stage can accept instruction this cycle
- instr  in  32  RV32 instruction word
- pc  in  SIZE  instruction address
- out_valid  out  1  operand bundle valid to execute stage
- out_ready  in  1  execute stage accepts bundle
- alu_in1, alu_in2  out  SIZE  operands to ALU/Branch_control data_in1/data_in2
- alu_en  out  1  ALU enable
- alu_select  out  4  ALU op code
- br_en  out  1  Branch_control enable
- br_select  out  3  branch compare code
- br_target  out  SIZE  pc + B-immediate
- rd_out  out  5  destination register (0 when none)
- illegal  out  1  unsupported instruction flag
- wb_valid  in  1  writeback strobe
- wb_rd  in  5  writeback register
- wb_data  in  SIZE  writeback value

## Operation
- Decoded ops; all others set illegal:
  - R-type (0110011): ADD→alu_select 0, SUB (funct7 0100000)→1, AND→2, OR→3; alu_in2=rs2.
  - I-type (0010011): ADDI→0, ANDI→2, ORI→3; alu_in2 = sign-extended instr[31:20].
  - B-type (1100011): br_en=1, alu_en=0, rd_out=0. Codes: BEQ→0, BNE→1, BLTU→3, BGEU→4. BLT/BGE are illegal, because Branch_control compares unsigned.
- Branch: br_target = pc + sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, modulo 2^SIZE.
- Illegal instruction: accepted and passed through with alu_en=0, br_en=0, illegal=1, rd_out=0. Does not touch the scoreboard.
- Register file:
  - 32×SIZE; x0 always reads 0.
  - Write when wb_valid && wb_rd!=0.
  - wb_rd=0 is ignored.
- Scoreboard pending[31:1]:
  - Set for rd on acceptance of an ALU instruction with rd!=0.
  - Cleared on wb_valid for wb_rd.
- Stall (instr_ready=0) when any of the following hold:
  - out_valid && !out_ready.
  - A used source rs1/rs2 (nonzero) is pending and not satisfied by bypass.
  - rd (nonzero, ALU instr) is already pending (WAW stall).
- Because the WAW stall blocks it, a set and clear of the same pending bit never occur in the same cycle.

## Timing
- Reset: out_valid=0, alu_en=0, br_en=0, illegal=0, alu_select=0, br_select=0, alu_in1/alu_in2/br_target=0, rd_out=0, all registers 0, pending all 0.
- Reset mid-operation drops any held bundle; no writeback is retained.
- Latency: instruction accepted at edge N (instr_valid && instr_ready) → bundle on outputs with out_valid=1 after edge N.
- Full throughput when no stall.
- Hold: while out_valid && !out_ready, all outputs remain stable.
- instr_ready is combinational: (!out_valid || out_ready) && !hazard.
- Writeback at edge N is visible to register reads from edge N onward. Same-cycle read of wb_rd is governed by OPSTAGE_BYPASS_EN.

## Configuration
- OPSTAGE_BYPASS_EN defined:
  - Same-cycle writeback forwarding: a source matching wb_rd while wb_valid takes wb_data.
  - That source counts as not pending.
- OPSTAGE_BYPASS_EN undefined:
  - No forwarding; the register is still pending that cycle, so the instruction stalls one extra cycle.
  - It issues the next cycle with the written value.

## Test plan
- Reset, then ADDI x1,x0,5 with out_ready=1 → next cycle out_valid=1, alu_select=0, alu_in1=0, alu_in2=5, rd_out=1, pending[1]=1.
- ADD x2,x1,x1 issued while x1 pending → instr_ready=0. Then wb_valid, wb_rd=1, wb_data=5:
  - With bypass: accepted the same cycle, alu_in1=alu_in2=5.
  - Without bypass: accepted one cycle later, operands 5.
- BNE x1,x2,-8 with pc=0x100 → br_en=1, br_select=1, alu_en=0, br_target=0xF8, rd_out=0.
- Backpressure: out_ready=0 for 3 cycles with a bundle held → outputs stable, instr_ready=0. Release → next instruction accepted on the same edge the bundle drains.
- BLT instruction, and wb_rd=0 with wb_data=0xFFFFFFFF:
  - BLT: illegal=1, alu_en=0, br_en=0.
  - x0 write: a subsequent read of x0 returns 0.
- Assert rst mid-stall with pending[3]=1 → immediately out_valid=0, pending cleared, ADD x4,x3,x3 accepted on the first cycle after reset release.
